even_parity_serial_rx: RTL and testbench
========================================

// Module: even_parity_serial_rx
// PURPOSE
//  Receive side of the even-parity path: a serial frame receiver that deserialises
//  DATA_W data bits, checks the trailing even-parity bit and checks the stop bit.
//  Frame: start(0), DATA_W data bits LSB first, parity bit, stop(1).
//  Sits behind the line interface; the bit-rate strobe comes from an external
//  baud/tick generator. Delivers one byte per frame to the consumer with error flags.
// PARAMETERS
//  DATA_W   8   number of data bits per frame (>=2)
// PORTS
//  clk         in   1       system clock, all logic on rising edge
//  rst         in   1       synchronous reset, active-high
//  bit_en      in   1       bit strobe; rx_in sampled only on cycles with bit_en=1
//  rx_in       in   1       serial line, idle high
//  data_out    out  DATA_W  last received data word, bit0 = first data bit on line
//  data_valid  out  1       one-cycle pulse: data_out/parity_err/frame_err updated
//  parity_err  out  1       1 = popcount(data bits + parity bit) odd
//  frame_err   out  1       1 = stop bit sampled as 0
//  busy        out  1       1 while a frame is in progress (state != IDLE)
// BEHAVIOUR
//  - One clock, synchronous active-high reset; all outputs registered.
//  - Reset: state=IDLE, bit count=0, shift reg=0, parity acc=0,
//    data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0.
//  - FSM advances only on bit_en=1 cycles. With bit_en=0, everything holds
//    except data_valid, which is 0.
//  - IDLE: rx_in=0 -> DATA, cnt=0, acc=0. rx_in=1 -> stay in IDLE.
//  - DATA: shift reg <= {rx_in, sreg[DATA_W-1:1]}, acc ^= rx_in, cnt++.
//    The DATA_W-th data bit (cnt==DATA_W-1) moves the FSM to PARITY.
//  - PARITY: acc ^= rx_in -> STOP.
//  - STOP: data_out<=sreg, parity_err<=acc, frame_err<=~rx_in, data_valid<=1 -> IDLE.
//  - Latency: data_valid is high in the cycle after the stop-bit strobe edge,
//    for exactly 1 cycle.
//  - Frames with errors are still delivered (data_valid=1). The flags mark the word.
//  - data_out and the error flags hold until the next data_valid.
//  - No start-bit glitch check: a 0 on any IDLE strobe starts a frame.
//  - Back-to-back frames: the start bit may arrive on the first strobe after STOP.
//  - bit_en may be high on consecutive cycles (1 bit/clk). There is no minimum gap.
//  - Reset mid-frame: the frame is discarded, with no data_valid.
//    The receiver is back in IDLE on the next cycle. Flags and data_out are cleared.
//  - busy=1 from the cycle after the start-bit strobe until the cycle after the
//    stop-bit strobe.
//  - Inputs are treated as already synchronous to clk. Metastability
//    synchronisation is upstream.
// TESTING
//  1 frame 0xA8, parity 1, stop 1 -> data_out=8'hA8, 1-cycle data_valid,
//    parity_err=0, frame_err=0.
//  2 frame 0xF0, parity 0, stop 1 -> data_out=8'hF0, parity_err=0, frame_err=0.
//  3 frame 0xF0, parity 1 (bad), stop 1 -> data_out=8'hF0, data_valid=1, parity_err=1.
//  4 frame 0x55, parity 0, stop 0 -> data_out=8'h55, frame_err=1, parity_err=0.
//  5 rst pulsed after 4 data bits -> no data_valid, busy=0 next cycle, outputs 0.
//    A following frame 0x3C (parity 0) is received clean.
//  6 bit_en with random 0-7 cycle gaps, rx_in toggled between strobes, 3 frames
//    back-to-back (0x00, 0xFF, 0x81) -> all three correct with flags 0.
//    An idle-high line with strobes -> busy stays 0.

Source files
------------

// File: rtl/even_parity_serial_rx_if.sv
// Bundle between the serial line/strobe source and the frame receiver,
// including the word-delivery outputs seen by the consumer.
interface even_parity_serial_rx_if #(
  parameter int DATA_W = 8
);
  logic              bit_en;
  logic              rx_in;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic              frame_err;
  logic              busy;

  // Handshake: data_valid is a one-cycle pulse with no ready/backpressure.
  // data_out, parity_err and frame_err are stable from that pulse until the next one.
  modport master (
    output bit_en, rx_in,
    input  data_out, data_valid, parity_err, frame_err, busy
  );

  modport slave (
    input  bit_en, rx_in,
    output data_out, data_valid, parity_err, frame_err, busy
  );
endinterface

// File: rtl/even_parity_serial_rx.sv
// Even-parity serial frame receiver: start(0), DATA_W data bits LSB first,
// parity, stop(1). Advances only on bit_en strobes; all outputs registered.
module even_parity_serial_rx #(
  parameter int DATA_W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  even_parity_serial_rx_if.slave       rx_if,
  output logic [1:0]                   state_dbg_o
);
  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic              acc_q, acc_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              busy_q, busy_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
      acc_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    acc_d   = acc_q;
    data_d  = data_q;
    valid_d = 1'b0;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    if (rx_if.bit_en) begin
      unique case (state_q)
        IDLE: begin
          // No glitch filtering: any low sample while idle is a start bit.
          if (!rx_if.rx_in) begin
            state_d = DATA;
            cnt_d   = '0;
            acc_d   = 1'b0;
          end
        end
        DATA: begin
          sreg_d = {rx_if.rx_in, sreg_q[DATA_W-1:1]};
          acc_d  = acc_q ^ rx_if.rx_in;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CNT_MAX) state_d = PARITY;
        end
        PARITY: begin
          acc_d   = acc_q ^ rx_if.rx_in;
          state_d = STOP;
        end
        STOP: begin
          data_d  = sreg_q;
          perr_d  = acc_q;
          ferr_d  = ~rx_if.rx_in;
          valid_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  assign rx_if.data_out   = data_q;
  assign rx_if.data_valid = valid_q;
  assign rx_if.parity_err = perr_q;
  assign rx_if.frame_err  = ferr_q;
  assign rx_if.busy       = busy_q;
  assign state_dbg_o      = state_q;
endmodule

// File: tb/tb_even_parity_serial_rx.sv
// Bench for even_parity_serial_rx: a frame-level model (bit queue per frame)
// predicts every output each cycle; directed frames pin the model with literals.
module tb_even_parity_serial_rx;
  localparam int DATA_W = 8;

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;

  even_parity_serial_rx_if #(.DATA_W(DATA_W)) rx_if ();

  even_parity_serial_rx #(.DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_if       (rx_if),
    .state_dbg_o (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // model: bits seen since the start bit, plus the expected registered outputs
  logic              bits_q[$];
  bit                in_frame;
  logic [DATA_W-1:0] exp_data;
  logic              exp_valid, exp_perr, exp_ferr;

  // scoreboard of words delivered by the model, drained when the DUT pulses
  logic [DATA_W+1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic en, input logic rx);
    logic [DATA_W-1:0] d;
    int ones;
    exp_valid = 1'b0;
    if (r) begin
      in_frame = 0;
      bits_q.delete();
      exp_data = '0;
      exp_perr = 1'b0;
      exp_ferr = 1'b0;
    end else if (en) begin
      if (!in_frame) begin
        if (rx == 1'b0) begin
          in_frame = 1;
          bits_q.delete();
        end
      end else begin
        bits_q.push_back(rx);
        if (bits_q.size() == DATA_W + 2) begin
          ones = 0;
          for (int i = 0; i < DATA_W; i++) begin
            d[i] = bits_q[i];
            ones += int'(bits_q[i]);
          end
          ones += int'(bits_q[DATA_W]);
          exp_data  = d;
          exp_perr  = (ones % 2) == 1;
          exp_ferr  = (bits_q[DATA_W+1] == 1'b0);
          exp_valid = 1'b1;
          exp_q.push_back({exp_perr, exp_ferr, exp_data});
          in_frame  = 0;
        end
      end
    end
  endtask

  // driver tasks: one tick = drive inputs, clock edge, advance model
  task automatic tick(input logic r, input logic en, input logic rx);
    rst          = r;
    rx_if.bit_en = en;
    rx_if.rx_in  = rx;
    @(posedge clk);
    model_step(r, en, rx);
    #1;
  endtask

  task automatic send_bit(input logic b, input int max_gap);
    int gap;
    gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    repeat (gap) tick(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    tick(1'b0, 1'b1, b);
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] d, input logic par,
                            input logic stp, input int max_gap);
    send_bit(1'b0, max_gap);
    for (int i = 0; i < DATA_W; i++) send_bit(d[i], max_gap);
    send_bit(par, max_gap);
    send_bit(stp, max_gap);
  endtask

  task automatic pin(input string name, input logic [DATA_W-1:0] d,
                     input logic pe, input logic fe);
    check({name, "_valid"}, 32'(rx_if.data_valid), 32'd1);
    check({name, "_data"},  32'(rx_if.data_out),   32'(d));
    check({name, "_perr"},  32'(rx_if.parity_err), 32'(pe));
    check({name, "_ferr"},  32'(rx_if.frame_err),  32'(fe));
  endtask

  // compare process: every cycle, DUT outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_valid", 32'(rx_if.data_valid), 32'(exp_valid));
      check("cyc_busy",  32'(rx_if.busy),       32'(in_frame));
      check("cyc_data",  32'(rx_if.data_out),   32'(exp_data));
      check("cyc_perr",  32'(rx_if.parity_err), 32'(exp_perr));
      check("cyc_ferr",  32'(rx_if.frame_err),  32'(exp_ferr));
      if (rx_if.data_valid === 1'b1) begin
        if (exp_q.size() == 0) check("sb_unexpected_word", 32'd1, 32'd0);
        else check("sb_word", 32'({rx_if.parity_err, rx_if.frame_err, rx_if.data_out}),
                   32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [DATA_W-1:0] rd;
    logic              rp, rs;
    rst = 1'b1;
    rx_if.bit_en = 1'b0;
    rx_if.rx_in  = 1'b1;
    in_frame = 0;
    exp_data = '0; exp_valid = 1'b0; exp_perr = 1'b0; exp_ferr = 1'b0;
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b0);
    chk_en = 1'b1;
    check("rst_busy",  32'(rx_if.busy),       32'd0);
    check("rst_valid", 32'(rx_if.data_valid), 32'd0);
    check("rst_data",  32'(rx_if.data_out),   32'd0);
    check("rst_state", 32'(state_dbg),        32'd0);
    tick(1'b0, 1'b0, 1'b1);

    // directed frames, back-to-back strobes
    send_frame(8'hA8, 1'b1, 1'b1, 0); pin("t1", 8'hA8, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b1, 0); pin("t2", 8'hF0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b1, 1'b1, 0); pin("t3", 8'hF0, 1'b1, 1'b0);
    send_frame(8'h55, 1'b0, 1'b0, 0); pin("t4", 8'h55, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    check("t4_hold_valid", 32'(rx_if.data_valid), 32'd0);
    check("t4_hold_data",  32'(rx_if.data_out),   32'h55);

    // reset mid-frame after 4 data bits
    send_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    check("t5_busy_pre", 32'(rx_if.busy), 32'd1);
    tick(1'b1, 1'b1, 1'b1);
    check("t5_busy",  32'(rx_if.busy),       32'd0);
    check("t5_valid", 32'(rx_if.data_valid), 32'd0);
    check("t5_data",  32'(rx_if.data_out),   32'd0);
    check("t5_ferr",  32'(rx_if.frame_err),  32'd0);
    send_frame(8'h3C, 1'b0, 1'b1, 0); pin("t5b", 8'h3C, 1'b0, 1'b0);

    // gapped strobes, noisy line between strobes, back-to-back frames
    send_frame(8'h00, 1'b0, 1'b1, 7); pin("t6a", 8'h00, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b1, 7); pin("t6b", 8'hFF, 1'b0, 1'b0);
    send_frame(8'h81, 1'b0, 1'b1, 7); pin("t6c", 8'h81, 1'b0, 1'b0);

    // idle-high line with strobes never starts a frame
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b1, 1'b1);
      check("t6_idle_busy", 32'(rx_if.busy), 32'd0);
    end

    // randomized frames with random parity/stop errors and gaps
    for (int f = 0; f < 40; f++) begin
      rd = DATA_W'($urandom);
      rp = ^rd ^ ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 4) != 0);
      send_frame(rd, rp, rs, int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 3)) tick(1'b0, 1'($urandom_range(0, 1)), 1'b1);
    end
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
